// File: rtl/osd_text_reader_if.sv
// Pixel-clock bus between the timing generator, text RAM, font ROM and the OSD reader.
interface osd_text_reader_if;
    logic        enable_osd;
    logic [11:0] x;
    logic [11:0] y;
    logic        de;
    logic [9:0]  ram_rdaddress;
    logic [7:0]  ram_q;
    logic [9:0]  font_rdaddress;
    logic [7:0]  font_q;
    logic        osd_active;
    logic        osd_pixel;

    modport master (
        input  enable_osd, x, y, de, ram_q, font_q,
        output ram_rdaddress, font_rdaddress, osd_active, osd_pixel
    );

    modport slave (
        output enable_osd, x, y, de, ram_q, font_q,
        input  ram_rdaddress, font_rdaddress, osd_active, osd_pixel
    );
endinterface

// File: rtl/osd_text_reader.sv
// OSD text scan-out: text RAM -> font ROM -> one pixel bit per clock, fixed 5-clock latency.
// Optional inverse video via text byte bit 7 when OSD_INVERSE_EN is defined.
module osd_text_reader #(
    parameter logic [11:0] OSD_X0 = 12'd64,
    parameter logic [11:0] OSD_Y0 = 12'd48,
    parameter int unsigned COLS   = 32,
    parameter int unsigned ROWS   = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    osd_text_reader_if.master  bus
);
    localparam int unsigned WIN_W = COLS * 8;
    localparam int unsigned WIN_H = ROWS * 8;
    localparam int unsigned NSTG  = 4;

    logic [11:0] dx_c, dy_c;
    logic        in_win_c, frame_start_c, pix_c;

    logic                  frame_en_q, frame_en_d;
    logic [9:0]            ram_addr_q, ram_addr_d;
    logic [9:0]            font_addr_q, font_addr_d;
    logic [1:0]            win_q, win_d;
    logic [NSTG-1:0]       act_q, act_d;
    logic [1:0][2:0]       line_q, line_d;
    logic [NSTG-1:0][2:0]  bit_q, bit_d;
    logic                  active_q, active_d;
    logic                  pixel_q, pixel_d;
`ifdef OSD_INVERSE_EN
    logic [1:0]            inv_q, inv_d;
`else
    logic                  unused_c;
    assign unused_c = bus.ram_q[7];
`endif

    // Window decode, frame-start enable sampling and pipeline advance
    always_comb begin
        dx_c          = bus.x - OSD_X0;
        dy_c          = bus.y - OSD_Y0;
        in_win_c      = bus.de && (bus.x >= OSD_X0) && (dx_c < 12'(WIN_W))
                        && (bus.y >= OSD_Y0) && (dy_c < 12'(WIN_H));
        frame_start_c = bus.de && (bus.x == 12'd0) && (bus.y == 12'd0);
        frame_en_d    = frame_start_c ? bus.enable_osd : frame_en_q;

        win_d  = {win_q[0], in_win_c};
        act_d  = {act_q[NSTG-2:0], in_win_c & frame_en_d};
        line_d = {line_q[0], dy_c[2:0]};
        bit_d  = {bit_q[NSTG-2:0], dx_c[2:0]};

        ram_addr_d  = in_win_c ? {dy_c[7:3], dx_c[7:3]} : ram_addr_q;
        font_addr_d = win_q[1] ? {bus.ram_q[6:0], line_q[1]} : font_addr_q;

        pix_c = bus.font_q[3'd7 - bit_q[NSTG-1]];
`ifdef OSD_INVERSE_EN
        inv_d = {inv_q[0], bus.ram_q[7]};
        pix_c = pix_c ^ inv_q[1];
`endif
        active_d = act_q[NSTG-1];
        pixel_d  = act_q[NSTG-1] & pix_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_en_q  <= 1'b0;
            ram_addr_q  <= '0;
            font_addr_q <= '0;
            win_q       <= '0;
            act_q       <= '0;
            line_q      <= '0;
            bit_q       <= '0;
            active_q    <= 1'b0;
            pixel_q     <= 1'b0;
`ifdef OSD_INVERSE_EN
            inv_q       <= '0;
`endif
        end else begin
            frame_en_q  <= frame_en_d;
            ram_addr_q  <= ram_addr_d;
            font_addr_q <= font_addr_d;
            win_q       <= win_d;
            act_q       <= act_d;
            line_q      <= line_d;
            bit_q       <= bit_d;
            active_q    <= active_d;
            pixel_q     <= pixel_d;
`ifdef OSD_INVERSE_EN
            inv_q       <= inv_d;
`endif
        end
    end

    assign bus.ram_rdaddress  = ram_addr_q;
    assign bus.font_rdaddress = font_addr_q;
    assign bus.osd_active     = active_q;
    assign bus.osd_pixel      = pixel_q;
endmodule

// File: tb/tb_osd_text_reader.sv
// Bench for osd_text_reader: directed steps plus random pixels checked against a cell/glyph model.
module tb_osd_text_reader;
    localparam int X0   = 64;
    localparam int Y0   = 48;
    localparam int COLS = 32;
    localparam int ROWS = 24;
`ifdef OSD_INVERSE_EN
    localparam int INV_EXP = 64;
`else
    localparam int INV_EXP = 0;
`endif

    typedef struct packed {
        logic act;
        logic pix;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] ram  [1024];
    logic [7:0] font [1024];
    exp_t exq [$];
    logic fen_m;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   act_cnt  = 0;
    int   pix_cnt  = 0;

    osd_text_reader_if bus ();

    osd_text_reader dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // 1-cycle synchronous text RAM and font ROM
    always @(posedge clk) begin
        bus.ram_q  <= ram[bus.ram_rdaddress];
        bus.font_q <= font[bus.font_rdaddress];
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one pixel, model its result, then check the output due from 4 pixels earlier
    task automatic cyc(input logic d, input int xi, input int yi, input logic en);
        exp_t e;
        int   cx, cy, ch, g, p;
        bus.de = d;
        bus.x = 12'(xi);
        bus.y = 12'(yi);
        bus.enable_osd = en;
        if (d && xi == 0 && yi == 0) fen_m = en;
        e = '0;
        if (d && fen_m && xi >= X0 && xi < X0 + COLS * 8 && yi >= Y0 && yi < Y0 + ROWS * 8) begin
            cx = xi - X0;
            cy = yi - Y0;
            ch = int'(ram[(cy / 8) * 32 + cx / 8]);
            g  = int'(font[(ch % 128) * 8 + cy % 8]);
            p  = (g >> (7 - cx % 8)) & 1;
`ifdef OSD_INVERSE_EN
            p  = p ^ (ch / 128);
`endif
            e.act = 1'b1;
            e.pix = p[0];
        end
        exq.push_back(e);
        @(posedge clk);
        #1;
        e = exq.pop_front();
        if (bus.osd_active === 1'b1) act_cnt++;
        if (bus.osd_pixel === 1'b1) pix_cnt++;
        chk("osd_active", 12'(bus.osd_active), 12'(e.act));
        chk("osd_pixel", 12'(bus.osd_pixel), 12'(e.pix));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 500, 500, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]  = 8'($urandom);
            font[i] = 8'($urandom);
        end
        ram[10'h045]  = 8'h41;
        font[10'h20E] = 8'b0001_0000;
        ram[3 * 32 + 7] = 8'hC2;
        for (int l = 0; l < 8; l++) font[8'h42 * 8 + l] = 8'h00;

        // Reset held with de/enable active, including a frame start and an in-window pixel
        fen_m = 1'b0;
        rst_n = 1'b0;
        bus.de = 1'b1;
        bus.enable_osd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.x = (i == 3) ? 12'd100 : 12'd0;
            bus.y = (i == 3) ? 12'd60 : 12'd0;
            @(posedge clk);
            #1;
            chk("rst_active", 12'(bus.osd_active), 12'd0);
            chk("rst_pixel", 12'(bus.osd_pixel), 12'd0);
            chk("rst_ram_addr", 12'(bus.ram_rdaddress), 12'd0);
            chk("rst_font_addr", 12'(bus.font_rdaddress), 12'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) exq.push_back('0);

        // Released mid-frame: no output before a frame start
        act_cnt = 0;
        for (int i = 0; i < 6; i++) cyc(1'b1, 100 + i, 60, 1'b1);
        idle(4);
        chk("post_rst_quiet", 12'(act_cnt), 12'd0);

        // Address mapping and pixel latency
        cyc(1'b1, 0, 0, 1'b1);
        idle(4);
        cyc(1'b1, X0 + 8 * 5 + 3, Y0 + 8 * 2 + 6, 1'b1);
        chk("ram_addr", 12'(bus.ram_rdaddress), 12'h045);
        cyc(1'b1, X0 + 8 * 5 + 2, Y0 + 8 * 2 + 6, 1'b1);
        cyc(1'b0, 500, 500, 1'b1);
        chk("font_addr", 12'(bus.font_rdaddress), 12'h20E);
        cyc(1'b0, 500, 500, 1'b1);
        cyc(1'b0, 500, 500, 1'b1);
        chk("pix_idx3_active", 12'(bus.osd_active), 12'd1);
        chk("pix_idx3", 12'(bus.osd_pixel), 12'd1);
        cyc(1'b0, 500, 500, 1'b1);
        chk("pix_idx2_active", 12'(bus.osd_active), 12'd1);
        chk("pix_idx2", 12'(bus.osd_pixel), 12'd0);
        idle(4);

        // Horizontal window edges on an in-window line
        act_cnt = 0;
        for (int xi = X0 - 1; xi <= X0 + COLS * 8; xi++) cyc(1'b1, xi, Y0 + 2, 1'b1);
        idle(4);
        chk("win_width", 12'(act_cnt), 12'(COLS * 8));

        // Vertical edges: lines just outside and inside the window
        act_cnt = 0;
        cyc(1'b1, X0 + 10, Y0 - 1, 1'b1);
        cyc(1'b1, X0 + 10, Y0, 1'b1);
        cyc(1'b1, X0 + 10, Y0 + ROWS * 8 - 1, 1'b1);
        cyc(1'b1, X0 + 10, Y0 + ROWS * 8, 1'b1);
        idle(4);
        chk("win_height", 12'(act_cnt), 12'd2);

        // Inverse-video cell sweep
        pix_cnt = 0;
        for (int l = 0; l < 8; l++)
            for (int c = 0; c < 8; c++) cyc(1'b1, X0 + 56 + c, Y0 + 24 + l, 1'b1);
        idle(4);
        chk("inverse_cell", 12'(pix_cnt), 12'(INV_EXP));

        // Enable dropped mid-frame takes effect only at the next frame start
        act_cnt = 0;
        cyc(1'b1, 100, 100, 1'b0);
        cyc(1'b1, 200, 200, 1'b0);
        idle(4);
        cyc(1'b1, 0, 0, 1'b0);
        cyc(1'b1, 100, 100, 1'b0);
        cyc(1'b1, 200, 200, 1'b1);
        idle(4);
        chk("enable_tear", 12'(act_cnt), 12'd2);

        // Random pixels with periodic frame starts
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) cyc(1'b1, 0, 0, 1'($urandom_range(0, 3) != 0));
            else cyc(1'($urandom_range(0, 7) != 0), $urandom_range(0, 400),
                     $urandom_range(0, 300), 1'($urandom));
        end
        // A short raster across the window
        cyc(1'b1, 0, 0, 1'b1);
        for (int yi = Y0 + 5; yi < Y0 + 8; yi++)
            for (int xi = X0 - 4; xi < X0 + COLS * 8 + 4; xi++) cyc(1'b1, xi, yi, 1'b1);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
